// File: rtl/smm_pkg.sv
// Shared constants, state encoding and bus-layout helper for the
// stream front/back end of the 4x4 Strassen multiplier.
package smm_pkg;

    localparam int DATAWIDTH = 32;
    localparam int DIM       = 4;
    localparam int N_ELEM    = DIM * DIM;
    localparam int BUSWIDTH  = DATAWIDTH * N_ELEM;
    localparam int CNT_W     = $clog2(N_ELEM);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        FIRE    = 3'd3,
        WAIT    = 3'd4,
        CAPTURE = 3'd5,
        DRAIN   = 3'd6
    } state_e;

    // Bit offset of element 'index' on a flattened matrix bus; element 0 at the LSBs.
    function automatic int unsigned elem_slice(input int unsigned index);
        return index * DATAWIDTH;
    endfunction

endpackage

// File: rtl/smm_mat_buffer.sv
// N_ELEM x DATAWIDTH matrix register file with an indexed write port,
// a whole-matrix parallel load port, a flat parallel read port and an
// indexed read port. Parallel load wins over an indexed write.
module smm_mat_buffer
    import smm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [CNT_W-1:0]     wr_idx_i,
    input  logic [DATAWIDTH-1:0] wr_data_i,
    input  logic                 ld_en_i,
    input  logic [BUSWIDTH-1:0]  ld_data_i,
    output logic [BUSWIDTH-1:0]  flat_o,
    input  logic [CNT_W-1:0]     rd_idx_i,
    output logic [DATAWIDTH-1:0] rd_data_o
);

    logic [DATAWIDTH-1:0] mem_q [N_ELEM];
    logic [DATAWIDTH-1:0] mem_d [N_ELEM];

    // Next contents: full-matrix load, single-element write, or hold.
    always_comb begin
        for (int i = 0; i < N_ELEM; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (ld_en_i) begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem_d[i] = ld_data_i[elem_slice(i) +: DATAWIDTH];
            end
        end else if (wr_en_i) begin
            mem_d[wr_idx_i] = wr_data_i;
        end else begin
            mem_d[0] = mem_q[0];
        end
    end

    // Storage registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Flatten the register file onto the matrix bus layout.
    always_comb begin
        flat_o = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            flat_o[elem_slice(i) +: DATAWIDTH] = mem_q[i];
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/smm_stream_ctrl.sv
// Stream front/back end for the 4x4 Strassen multiplier: collects A then
// B from an input stream, fires the multiplier, waits its fixed latency,
// captures C and streams the 16 result elements out row-major.
module smm_stream_ctrl
    import smm_pkg::*;
#(
    parameter int MM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 sel_mode,
    output logic [BUSWIDTH-1:0]  mm_A,
    output logic [BUSWIDTH-1:0]  mm_B,
    output logic                 mm_load,
    output logic                 mm_sel,
    input  logic [BUSWIDTH-1:0]  mm_C,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int WAIT_W = $clog2(MM_LATENCY + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_ELEM - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MM_LATENCY - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    elem_cnt_q, elem_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mm_sel_q, mm_sel_d;

    logic                a_wr_s, b_wr_s, res_ld_s;
    logic                in_ready_s, out_valid_s, in_hs_s, out_hs_s;
    logic [DATAWIDTH-1:0] res_rd_s;
    logic [DATAWIDTH-1:0] a_rd_unused_s, b_rd_unused_s;
    logic [BUSWIDTH-1:0]  res_flat_unused_s;

    // Output decode from the registered state.
    always_comb begin
        in_ready_s  = (state_q == LOAD_A) || (state_q == LOAD_B);
        out_valid_s = (state_q == DRAIN);
        busy        = !((state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B));
        mm_load     = (state_q == FIRE);
        out_last    = (state_q == DRAIN) && (out_cnt_q == LAST_IDX);
        if (state_q == DRAIN) begin
            out_data = res_rd_s;
        end else begin
            out_data = '0;
        end
    end

    assign in_hs_s   = in_valid && in_ready_s;
    assign out_hs_s  = out_valid_s && out_ready;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign mm_sel    = mm_sel_q;

    // Next-state, counter and buffer-strobe logic of the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        out_cnt_d  = out_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mm_sel_d   = mm_sel_q;
        a_wr_s     = 1'b0;
        b_wr_s     = 1'b0;
        res_ld_s   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = LOAD_A;
            end
            LOAD_A, LOAD_B: begin
                if (in_hs_s) begin
                    a_wr_s = (state_q == LOAD_A);
                    b_wr_s = (state_q == LOAD_B);
                    if (elem_cnt_q == LAST_IDX) begin
                        elem_cnt_d = '0;
                        state_d    = (state_q == LOAD_A) ? LOAD_B : FIRE;
                    end else begin
                        elem_cnt_d = elem_cnt_q + CNT_W'(1);
                    end
                end else begin
                    elem_cnt_d = elem_cnt_q;
                end
            end
            FIRE: begin
                mm_sel_d   = sel_mode;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // Terminal count reached after MM_LATENCY cycles in WAIT.
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d = CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            CAPTURE: begin
                res_ld_s  = 1'b1;
                out_cnt_d = '0;
                state_d   = DRAIN;
            end
            DRAIN: begin
                if (out_hs_s) begin
                    if (out_cnt_q == LAST_IDX) begin
                        out_cnt_d = '0;
                        state_d   = LOAD_A;
                    end else begin
                        out_cnt_d = out_cnt_q + CNT_W'(1);
                    end
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            elem_cnt_q <= '0;
            out_cnt_q  <= '0;
            wait_cnt_q <= '0;
            mm_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mm_sel_q   <= mm_sel_d;
        end
    end

    smm_mat_buffer u_buf_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (a_wr_s),
        .wr_idx_i  (elem_cnt_q),
        .wr_data_i (in_data),
        .ld_en_i   (1'b0),
        .ld_data_i ({BUSWIDTH{1'b0}}),
        .flat_o    (mm_A),
        .rd_idx_i  (out_cnt_q),
        .rd_data_o (a_rd_unused_s)
    );

    smm_mat_buffer u_buf_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (b_wr_s),
        .wr_idx_i  (elem_cnt_q),
        .wr_data_i (in_data),
        .ld_en_i   (1'b0),
        .ld_data_i ({BUSWIDTH{1'b0}}),
        .flat_o    (mm_B),
        .rd_idx_i  (out_cnt_q),
        .rd_data_o (b_rd_unused_s)
    );

    smm_mat_buffer u_buf_res (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (1'b0),
        .wr_idx_i  ({CNT_W{1'b0}}),
        .wr_data_i ({DATAWIDTH{1'b0}}),
        .ld_en_i   (res_ld_s),
        .ld_data_i (mm_C),
        .flat_o    (res_flat_unused_s),
        .rd_idx_i  (out_cnt_q),
        .rd_data_o (res_rd_s)
    );

endmodule

// File: tb/tb_smm_stream_ctrl.sv
// Self-checking bench for smm_stream_ctrl: a transaction-level reference
// (accepted words -> matrix product queue, timing from handshake cycles)
// plus a multiplier stand-in that presents C only on the sampling cycle.
module tb_smm_stream_ctrl;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'd0;
    logic         sel_mode = 1'b0;
    logic [511:0] mm_A, mm_B, mm_C;
    logic         mm_load, mm_sel;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last, busy;

    smm_stream_ctrl #(.MM_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sel_mode(sel_mode), .mm_A(mm_A), .mm_B(mm_B),
        .mm_load(mm_load), .mm_sel(mm_sel), .mm_C(mm_C),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          cyc = 0;
    int          ready_from = 2;
    int          n_in = 0;
    int          load_cyc = -100;
    int          h32_cyc = -100;
    int          obs_load_cyc = -100;
    int          obs_rise_cyc = -100;
    bit          ov_prev = 1'b0;
    bit          blk = 1'b0;
    logic [31:0] rec [32];
    logic [31:0] expq [$];
    int          n_out_total = 0;
    logic [31:0] got [512];
    logic [511:0] snap_a, snap_b, prod;
    logic        sel_snap;
    int          or_mode = 0;
    int          or_cnt = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [511:0] mmul(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] r;
        logic [31:0]  s;
        r = '0;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                s = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    s = s + a[(rr*4+k)*32 +: 32] * b[(k*4+cc)*32 +: 32];
                end
                r[(rr*4+cc)*32 +: 32] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [511:0] garbage();
        logic [511:0] g;
        for (int i = 0; i < 16; i++) g[i*32 +: 32] = $urandom;
        return g;
    endfunction

    // Per-cycle compare against the model, multiplier stand-in, model update.
    always @(negedge clk) begin
        bit e_rdy, e_load, e_ov;
        logic [31:0] s;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_mm_load", mm_load, 0);
            chk("rst_mm_sel", mm_sel, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mm_A", mm_A, 0);
            chk("rst_mm_B", mm_B, 0);
            n_in = 0;
            blk = 1'b0;
            expq.delete();
            ready_from = cyc + 2;
            load_cyc = -100;
            mm_C = garbage();
        end else begin
            e_rdy  = !blk && (cyc >= ready_from);
            e_load = blk && (cyc == load_cyc);
            e_ov   = blk && (cyc >= load_cyc + L + 2);
            chk("in_ready", in_ready, e_rdy);
            chk("mm_load", mm_load, e_load);
            chk("busy", busy, blk);
            chk("out_valid", out_valid, e_ov);
            if (mm_load) obs_load_cyc = cyc;
            if (out_valid && !ov_prev) obs_rise_cyc = cyc;
            if (e_ov && expq.size() > 0) begin
                chk("out_data", out_data, expq[0]);
                chk("out_last", out_last, expq.size() == 1);
            end
            if (e_load) begin
                snap_a = mm_A;
                snap_b = mm_B;
                sel_snap = sel_mode;
                prod = mmul(mm_A, mm_B);
            end
            if (blk && cyc > load_cyc && cyc <= load_cyc + L + 1) begin
                chk("mm_A_hold", mm_A, snap_a);
                chk("mm_B_hold", mm_B, snap_b);
                chk("mm_sel", mm_sel, sel_snap);
            end
            if (blk && cyc == load_cyc + L + 1) mm_C = prod;
            else mm_C = garbage();
            // handshakes completing at the coming rising edge
            if (e_rdy && in_valid) begin
                rec[n_in] = in_data;
                n_in++;
                if (n_in == 32) begin
                    h32_cyc = cyc;
                    blk = 1'b1;
                    load_cyc = cyc + 1;
                    n_in = 0;
                    for (int rr = 0; rr < 4; rr++) begin
                        for (int cc = 0; cc < 4; cc++) begin
                            s = 32'd0;
                            for (int k = 0; k < 4; k++) s = s + rec[rr*4+k] * rec[16+k*4+cc];
                            expq.push_back(s);
                        end
                    end
                end
            end
            if (e_ov && out_ready && expq.size() > 0) begin
                got[n_out_total % 512] = out_data;
                n_out_total++;
                void'(expq.pop_front());
                if (expq.size() == 0) begin
                    blk = 1'b0;
                    ready_from = cyc + 1;
                end
            end
        end
        ov_prev = out_valid;
        cyc++;
    end

    // Downstream ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = (or_cnt % 3 == 0);
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            or_cnt++;
        end
    end

    task automatic send(input logic [31:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = d;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && !rst) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_handshake_timeout cyc=%0d got no ready want ready", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(input int target);
        for (int t = 0; t < 3000 && n_out_total < target; t++) begin
            @(posedge clk);
            #1;
        end
        chk("output_count", n_out_total, target);
    endtask

    task automatic run_txn(input logic [31:0] a [16], input logic [31:0] b [16],
                           input logic sel, input int gap, input bit hold_dead);
        int base;
        base = n_out_total;
        sel_mode = sel;
        for (int i = 0; i < 32; i++) begin
            send(i < 16 ? a[i] : b[i-16], gap < 0 ? $urandom_range(0, 3) : gap);
        end
        if (hold_dead) begin
            in_valid = 1'b1;
            in_data = 32'hDEADBEEF;
        end else begin
            in_valid = 1'b0;
        end
        wait_outputs(base + 16);
    endtask

    logic [31:0] ident [16], seq [16], ones [16], twos [16], ra [16], rb [16];
    int base;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ident[i] = (i / 4 == i % 4) ? 32'd1 : 32'd0;
            seq[i]   = 32'(i + 1);
            ones[i]  = 32'd1;
            twos[i]  = 32'd2;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: identity x 1..16, free-flowing output
        base = n_out_total;
        or_mode = 0;
        run_txn(ident, seq, 1'b1, 0, 1'b0);
        for (int k = 0; k < 16; k++) chk("t1_value", got[(base+k)%512], 32'(k + 1));
        chk("t1_load_latency", obs_load_cyc - h32_cyc, 1);
        chk("t1_valid_rise", obs_rise_cyc - obs_load_cyc, L + 2);

        // 2: all ones x all twos, sel 0
        base = n_out_total;
        run_txn(ones, twos, 1'b0, 0, 1'b0);
        for (int k = 0; k < 16; k++) chk("t2_value", got[(base+k)%512], 32'd8);

        // 3: sparse input, stalled output
        base = n_out_total;
        or_mode = 1;
        run_txn(ident, seq, 1'b1, 2, 1'b0);
        for (int k = 0; k < 16; k++) chk("t3_value", got[(base+k)%512], 32'(k + 1));

        // 4: in_valid held with junk through WAIT/DRAIN, then next A0 accepted
        or_mode = 0;
        run_txn(ones, twos, 1'b0, 0, 1'b1);
        base = n_out_total;
        run_txn(ident, seq, 1'b0, 0, 1'b0);
        for (int k = 0; k < 16; k++) chk("t4_value", got[(base+k)%512], 32'(k + 1));

        // 5: asynchronous reset after B element 7
        for (int i = 0; i < 16; i++) send(ident[i], 0);
        for (int i = 0; i < 8; i++) send(seq[i], 0);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("t5_async_in_ready", in_ready, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_mm_load", mm_load, 0);
        chk("t5_async_mm_A", mm_A, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        base = n_out_total;
        run_txn(ones, twos, 1'b0, 0, 1'b0);
        for (int k = 0; k < 16; k++) chk("t5_value", got[(base+k)%512], 32'd8);

        // 6: back-to-back transactions
        base = n_out_total;
        run_txn(ident, seq, 1'b1, 0, 1'b0);
        run_txn(ones, twos, 1'b0, 0, 1'b0);
        for (int k = 0; k < 16; k++) chk("t6_value_a", got[(base+k)%512], 32'(k + 1));
        for (int k = 0; k < 16; k++) chk("t6_value_b", got[(base+16+k)%512], 32'd8);
        chk("t6_load_latency", obs_load_cyc - h32_cyc, 1);

        // randomized transactions against the model
        or_mode = 2;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) begin
                ra[i] = $urandom;
                rb[i] = $urandom;
            end
            run_txn(ra, rb, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
